result_display_mux: RTL

//  Read side of the 2-bit ALU result register.
//  - Captures the registered result plus Z/C/V flags on a load strobe.
//  - Time-multiplexes the snapshot onto a 4-digit seven-segment display
//    (result, C, Z, V). Sits between reg_2bit/flag regs and board pins.
//  - Blinks the result digit while V=1.

---
 rtl/fac_p1_pkg.sv | 12 +
 rtl/seg7_decoder.sv | 15 +
 rtl/result_display_mux.sv | 91 +++++++++
 3 files changed

// File: rtl/fac_p1_pkg.sv
// fac_p1_pkg: display FSM states and active-low seven-segment glyph constants
package fac_p1_pkg;

    typedef enum logic {BLANK, SHOW} disp_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 2-bit value to active-low gfedcba glyph
module seg7_decoder
    import fac_p1_pkg::*;
(
    input  logic [1:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = (value_i == 2'd0) ? GLYPH_0 :
                (value_i == 2'd1) ? GLYPH_1 :
                (value_i == 2'd2) ? GLYPH_2 : GLYPH_3;
    end

endmodule

// File: rtl/result_display_mux.sv
// result_display_mux: snapshots ALU result/flags and multiplexes them onto a
// 4-digit active-low seven-segment display, blinking the result on overflow
module result_display_mux
    import fac_p1_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] result,
    input  logic [2:0] flags,
    input  logic       load,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       showing
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    disp_state_t state_q, state_d;
    logic [1:0]  snap_res_q, snap_res_d;
    logic [2:0]  snap_flg_q, snap_flg_d;
    logic [1:0]  idx_q, idx_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic        bph_q, bph_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        showing_q;
    logic        rwrap, bwrap, blank_digit;
    logic [1:0]  digit_val;
    logic [6:0]  glyph;

    seg7_decoder u_dec (
        .value_i (digit_val),
        .seg_o   (glyph)
    );

    // clr dominates load; counters free-run regardless of state
    always_comb begin
        rwrap       = rcnt_q == RW'(REFRESH_DIV - 1);
        bwrap       = bcnt_q == BW'(BLINK_DIV - 1);
        state_d     = clr ? BLANK : load ? SHOW : state_q;
        snap_res_d  = clr ? 2'b00 : load ? result : snap_res_q;
        snap_flg_d  = clr ? 3'b000 : load ? flags : snap_flg_q;
        rcnt_d      = rwrap ? '0 : rcnt_q + 1'b1;
        idx_d       = rwrap ? idx_q + 2'd1 : idx_q;
        bcnt_d      = bwrap ? '0 : bcnt_q + 1'b1;
        bph_d       = bwrap ? ~bph_q : bph_q;
        digit_val   = (idx_q == 2'd0) ? snap_res_q :
                      {1'b0, (idx_q == 2'd1) ? snap_flg_q[1] :
                             (idx_q == 2'd2) ? snap_flg_q[0] : snap_flg_q[2]};
        blank_digit = (idx_q == 2'd0) && snap_flg_q[2] && bph_q;
        seg_d       = (state_q == SHOW && !blank_digit) ? glyph : SEG_OFF;
        an_d        = (state_q == SHOW) ? ~(4'b0001 << idx_q) : 4'hF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            snap_res_q <= 2'b00;
            snap_flg_q <= 3'b000;
            idx_q      <= 2'd0;
            rcnt_q     <= '0;
            bcnt_q     <= '0;
            bph_q      <= 1'b0;
            seg_q      <= SEG_OFF;
            an_q       <= 4'hF;
            showing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_res_q <= snap_res_d;
            snap_flg_q <= snap_flg_d;
            idx_q      <= idx_d;
            rcnt_q     <= rcnt_d;
            bcnt_q     <= bcnt_d;
            bph_q      <= bph_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            showing_q  <= state_q == SHOW;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign showing = showing_q;

endmodule
